// File: rtl/alu_seq.sv
// alu_seq -- handshaked execute-stage ALU with an iterative RV32M datapath.
//
// Base RV32I register/immediate ops complete one edge after accept.
// MUL*/DIV*/REM* run a one-bit-per-cycle shift-add / restoring
// shift-subtract loop (XLEN steps), followed by one sign-fix cycle.
// Divide-by-zero and signed divide overflow complete in a single edge.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   kill             synchronous abort; returns to IDLE and drops any result
//   in_valid/ready   request handshake (ready only in IDLE)
//   funct3, funct7   operation select
//   src_sel          1 = reg_data_2, 0 = immediate as operand B
//   reg_data_1       operand A
//   reg_data_2       operand B (register)
//   immediate        operand B (immediate)
//   out_valid/ready  result handshake (valid only in DONE)
//   alu_res          registered result
//   busy             high whenever the FSM is not IDLE
module alu_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            src_sel,
  input  logic [XLEN-1:0] reg_data_1,
  input  logic [XLEN-1:0] reg_data_2,
  input  logic [XLEN-1:0] immediate,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_res,
  output logic            busy
);

  localparam int SH_W = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  logic [1:0]        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [XLEN-1:0]   alu_res_reg;
  // Shared iteration register: MUL keeps {partial product, multiplier},
  // DIV keeps {partial remainder, dividend bits still to shift in}.
  logic [2*XLEN-1:0] acc_reg;
  logic [XLEN-1:0]   opb_reg;       // multiplicand or divisor magnitude
  logic [2:0]        f3_reg;
  logic              neg_res_reg;   // negate product / quotient in FIX
  logic              neg_rem_reg;   // negate remainder in FIX

  // ---------------- operand select and decode ----------------
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [SH_W-1:0] shamt;
  logic            is_m;
  logic            is_sub;
  logic            is_sra;

  assign op_a   = reg_data_1;
  assign op_b   = src_sel ? reg_data_2 : immediate;
  assign shamt  = op_b[SH_W-1:0];
  assign is_m   = src_sel && (funct7 == 7'b0000001);
  assign is_sub = (funct3 == 3'b000) && src_sel && (funct7 == 7'b0100000);
  assign is_sra = (funct3 == 3'b101) && (funct7 == 7'b0100000);

  // Bitwise logic ops, one cell per bit.
  logic [XLEN-1:0] and_bits;
  logic [XLEN-1:0] or_bits;
  logic [XLEN-1:0] xor_bits;

  genvar gi;
  generate
    for (gi = 0; gi < XLEN; gi++) begin : g_logic
      assign and_bits[gi] = op_a[gi] & op_b[gi];
      assign or_bits[gi]  = op_a[gi] | op_b[gi];
      assign xor_bits[gi] = op_a[gi] ^ op_b[gi];
    end
  endgenerate

  logic signed [XLEN-1:0] sra_val;
  assign sra_val = $signed(op_a) >>> shamt;

  logic [XLEN-1:0] base_res;
  always_comb begin
    base_res = '0;
    case (funct3)
      3'b000: base_res = is_sub ? (op_a - op_b) : (op_a + op_b);
      3'b001: base_res = op_a << shamt;
      3'b010: base_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      3'b011: base_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      3'b100: base_res = xor_bits;
      3'b101: base_res = is_sra ? sra_val : (op_a >> shamt);
      3'b110: base_res = or_bits;
      default: base_res = and_bits;
    endcase
  end

  // ---------------- M-extension setup ----------------
  // funct3[2] selects the divide group; funct3[1] selects REM within it.
  logic            m_div;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_res;

  assign m_div    = funct3[2];
  assign a_signed = m_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign b_signed = m_div ? ~funct3[0] : ~funct3[1];
  assign a_neg    = a_signed & op_a[XLEN-1];
  assign b_neg    = b_signed & op_b[XLEN-1];
  assign a_mag    = a_neg ? (-op_a) : op_a;
  assign b_mag    = b_neg ? (-op_b) : op_b;
  assign div_zero = m_div && (op_b == '0);
  assign div_ovf  = m_div && ~funct3[0] && (op_a == MOST_NEG) && (op_b == ALL_ONES);

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = funct3[1] ? op_a : ALL_ONES;
    end else begin
      special_res = funct3[1] ? '0 : op_a;
    end
  end

  // ---------------- iteration step ----------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;

  assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} +
                    (acc_reg[0] ? {1'b0, opb_reg} : {(XLEN+1){1'b0}});
  assign mul_next = {mul_sum, acc_reg[XLEN-1:1]};

  // A partial remainder is always below the divisor, so a negative
  // difference implies the shifted value fits in XLEN bits.
  assign div_shift = acc_reg[2*XLEN-1:XLEN-1];
  assign div_diff  = div_shift - {1'b0, opb_reg};
  assign div_next  = div_diff[XLEN] ?
                     {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0} :
                     {div_diff[XLEN-1:0],  acc_reg[XLEN-2:0], 1'b1};

  // ---------------- sign fix-up ----------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_res;

  assign prod_fix = neg_res_reg ? (-acc_reg) : acc_reg;
  assign quo_fix  = neg_res_reg ? (-acc_reg[XLEN-1:0]) : acc_reg[XLEN-1:0];
  assign rem_fix  = neg_rem_reg ? (-acc_reg[2*XLEN-1:XLEN]) : acc_reg[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = '0;
    case (f3_reg)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  // ---------------- state ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      alu_res_reg <= '0;
      acc_reg     <= '0;
      opb_reg     <= '0;
      f3_reg      <= '0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
    end else if (kill) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            if (!is_m) begin
              alu_res_reg <= base_res;
              state_reg   <= S_DONE;
            end else if (div_zero || div_ovf) begin
              alu_res_reg <= special_res;
              state_reg   <= S_DONE;
            end else begin
              acc_reg     <= m_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
              opb_reg     <= m_div ? b_mag : a_mag;
              f3_reg      <= funct3;
              neg_res_reg <= a_neg ^ b_neg;
              neg_rem_reg <= a_neg;
              cnt_reg     <= CNT_W'(XLEN);
              state_reg   <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          acc_reg <= f3_reg[2] ? div_next : mul_next;
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= S_FIX;
          end
        end
        S_FIX: begin
          alu_res_reg <= fix_res;
          state_reg   <= S_DONE;
        end
        default: begin
          if (out_ready) begin
            state_reg <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready  = (state_reg == S_IDLE);
  assign out_valid = (state_reg == S_DONE);
  assign busy      = (state_reg != S_IDLE);
  assign alu_res   = alu_res_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (XLEN = 32).
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        kill;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        src_sel;
  logic [31:0] reg_data_1;
  logic [31:0] reg_data_2;
  logic [31:0] immediate;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_res;
  logic        busy;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_M    = 7'b0000001;

  alu_seq dut (
    .clk(clk), .rst(rst), .kill(kill),
    .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .funct7(funct7), .src_sel(src_sel),
    .reg_data_1(reg_data_1), .reg_data_2(reg_data_2), .immediate(immediate),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_res(alu_res), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [2:0] f3, input logic [6:0] f7, input logic sel,
                           input logic [31:0] a, input logic [31:0] b);
    funct3     = f3;
    funct7     = f7;
    src_sel    = sel;
    reg_data_1 = a;
    if (sel) begin
      reg_data_2 = b;
      immediate  = $urandom;
    end else begin
      immediate  = b;
      reg_data_2 = $urandom;
    end
    in_valid = 1'b1;
  endtask

  // Scramble inputs after accept; the DUT must have registered what it needs.
  task automatic scramble();
    in_valid   = 1'b0;
    reg_data_1 = $urandom;
    reg_data_2 = $urandom;
    immediate  = $urandom;
    funct3     = 3'($urandom);
    funct7     = 7'($urandom);
    src_sel    = 1'($urandom);
  endtask

  // Called #1 after a clock edge with the DUT idle; returns the same way.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [6:0] f7,
                       input logic sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_lat);
    int lat;
    check({tag, " in_ready idle"}, {31'b0, in_ready}, 32'd1);
    drive_req(f3, f7, sel, a, b);
    out_ready = 1'b1;
    @(posedge clk); #1;
    scramble();
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, alu_res, exp_res);
    check({tag, " in_ready done"}, {31'b0, in_ready}, 32'd0);
    $display("op %-8s a=0x%08h b=0x%08h res=0x%08h exp=0x%08h lat=%0d", tag, a, b, alu_res, exp_res, lat);
    @(posedge clk); #1;
    check({tag, " out_valid drop"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [31:0] held;

    rst = 1'b1; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    funct3 = '0; funct7 = '0; src_sel = 1'b0;
    reg_data_1 = '0; reg_data_2 = '0; immediate = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset in_ready", {31'b0, in_ready}, 32'd1);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset alu_res", alu_res, 32'd0);
    $display("reset: in_ready=%0b out_valid=%0b busy=%0b alu_res=0x%08h", in_ready, out_valid, busy, alu_res);

    // Base ops
    do_op("ADD", 3'b000, F7_BASE, 1'b1, 32'd5, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1);
    do_op("SRAI", 3'b101, F7_ALT, 1'b0, 32'h8000_0000, 32'd4, 32'hF800_0000, 1);
    do_op("SRL", 3'b101, F7_BASE, 1'b1, 32'h8000_0000, 32'd4, 32'h0800_0000, 1);
    do_op("SUB", 3'b000, F7_ALT, 1'b1, 32'd10, 32'd3, 32'd7, 1);
    do_op("SLT", 3'b010, F7_BASE, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    do_op("SLTU", 3'b011, F7_BASE, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);

    // Iterative multiply
    do_op("MUL", 3'b000, F7_M, 1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    do_op("MULH", 3'b001, F7_M, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    do_op("MULHU", 3'b011, F7_M, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    do_op("MULHSU", 3'b010, F7_M, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34);

    // Iterative divide
    do_op("DIV", 3'b100, F7_M, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    do_op("REM", 3'b110, F7_M, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    do_op("DIVU", 3'b101, F7_M, 1'b1, 32'd1000, 32'd7, 32'd142, 34);
    do_op("REMU", 3'b111, F7_M, 1'b1, 32'd1000, 32'd7, 32'd6, 34);

    // Special divide cases
    do_op("DIVU/0", 3'b101, F7_M, 1'b1, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("REMU/0", 3'b111, F7_M, 1'b1, 32'd100, 32'd0, 32'd100, 1);
    do_op("DIVovf", 3'b100, F7_M, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("REMovf", 3'b110, F7_M, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Backpressure: XOR held in DONE for 10 cycles
    out_ready = 1'b0;
    drive_req(3'b100, F7_BASE, 1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    @(posedge clk); #1;
    scramble();
    check("bp out_valid", {31'b0, out_valid}, 32'd1);
    check("bp result", alu_res, 32'hFF00_FF00);
    held = 32'hFF00_FF00;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp hold valid", {31'b0, out_valid}, 32'd1);
      check("bp hold res", alu_res, held);
      check("bp hold in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release valid", {31'b0, out_valid}, 32'd0);
    check("bp release in_ready", {31'b0, in_ready}, 32'd1);
    $display("op XOR-bp  res=0x%08h held 10 cycles, released", held);

    // Reset mid-BUSY of a MUL
    drive_req(3'b000, F7_M, 1'b1, 32'd123, 32'd456);
    @(posedge clk); #1;
    scramble();
    repeat (5) @(posedge clk);
    #1;
    check("mul busy before rst", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst mid out_valid", {31'b0, out_valid}, 32'd0);
    check("rst mid in_ready", {31'b0, in_ready}, 32'd1);
    check("rst mid busy", {31'b0, busy}, 32'd0);
    check("rst mid alu_res", alu_res, 32'd0);
    $display("reset mid-MUL: in_ready=%0b out_valid=%0b busy=%0b alu_res=0x%08h", in_ready, out_valid, busy, alu_res);

    // Kill at counter=16 of a DIVU
    drive_req(3'b101, F7_M, 1'b1, 32'd1000, 32'd7);
    @(posedge clk); #1;
    scramble();
    repeat (16) @(posedge clk);
    #1;
    check("kill pre busy", {31'b0, busy}, 32'd1);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill busy", {31'b0, busy}, 32'd0);
    check("kill in_ready", {31'b0, in_ready}, 32'd1);
    check("kill out_valid", {31'b0, out_valid}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) pulses++;
    end
    check("kill no pulse", 32'(pulses), 32'd0);
    $display("kill DIVU at cnt=16: out_valid pulses after kill=%0d", pulses);
    do_op("ADDpost", 3'b000, F7_BASE, 1'b1, 32'd1, 32'd1, 32'd2, 1);

    lat = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
